// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, flush and registered in_ready.
// Optional perf counters (stall_cnt, flush_cnt) are enabled by defining STAGE_PERF_EN.
module pipe_skid_reg #(
  parameter int unsigned             CTRL_WIDTH = 16,
  parameter int unsigned             DATA_WIDTH = 32,
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   PC_ADDR    = ADDR_WIDTH'(32'h8000_0000),
  parameter logic [CTRL_WIDTH-1:0]   CTRL_RESET = '0,
  parameter int unsigned             CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
`ifdef STAGE_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HEAD  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic [ADDR_WIDTH-1:0] skid_pc;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  accept;
  logic                  take;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  // Bubbles must never present live control bits downstream.
  assign out_ctrl = out_valid ? head_ctrl : CTRL_RESET;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
      head_ctrl <= CTRL_RESET;
      out_pc    <= PC_ADDR;
      out_data  <= '0;
      skid_ctrl <= CTRL_RESET;
      skid_pc   <= PC_ADDR;
      skid_data <= '0;
    end else if (flush) begin
      // Flush wins over any accept/take in the same cycle.
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
      head_ctrl <= CTRL_RESET;
      out_data  <= '0;
      if (in_valid) out_pc <= in_pc;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state     <= HEAD;
            out_valid <= 1'b1;
            occupancy <= 2'd1;
            head_ctrl <= in_ctrl;
            out_pc    <= in_pc;
            out_data  <= in_data;
          end
        end
        HEAD: begin
          if (accept && take) begin
            head_ctrl <= in_ctrl;
            out_pc    <= in_pc;
            out_data  <= in_data;
          end else if (accept) begin
            state     <= FULL;
            in_ready  <= 1'b0;
            occupancy <= 2'd2;
            skid_ctrl <= in_ctrl;
            skid_pc   <= in_pc;
            skid_data <= in_data;
          end else if (take) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
          end
        end
        FULL: begin
          if (take) begin
            state     <= HEAD;
            in_ready  <= 1'b1;
            occupancy <= 2'd1;
            head_ctrl <= skid_ctrl;
            out_pc    <= skid_pc;
            out_data  <= skid_data;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          occupancy <= 2'd0;
        end
      endcase
    end
  end

`ifdef STAGE_PERF_EN
  // Free-running wrap-around counters for stall and flush cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (flush)                   flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomized bench for pipe_skid_reg against a queue-based model of the stage.
// Define STAGE_PERF_EN to also check the perf counters (small CNT_WIDTH exercises wrap).
module tb_pipe_skid_reg;
  localparam int unsigned CW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NW = 3;
  localparam logic [AW-1:0] PC0 = 32'h8000_0000;
  localparam logic [CW-1:0] CR  = 16'h0004;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [AW-1:0] in_pc, out_pc;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
`ifdef STAGE_PERF_EN
  logic [NW-1:0] stall_cnt, flush_cnt;
`endif

  pipe_skid_reg #(
    .CTRL_WIDTH(CW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .PC_ADDR(PC0), .CTRL_RESET(CR), .CNT_WIDTH(NW)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_pc(in_pc), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_pc(out_pc), .out_data(out_data),
    .occupancy(occupancy)
`ifdef STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          q[$];
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_data;
  int            m_stall, m_flush;
  logic [AW-1:0] taken[$];
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_pc    = PC0;
    m_data  = '0;
    m_stall = 0;
    m_flush = 0;
  endfunction

  task automatic check_outputs();
    bit has = (q.size() > 0);
    check("out_valid", 64'(out_valid), 64'(has));
    check("in_ready",  64'(in_ready),  64'(q.size() != 2));
    check("occupancy", 64'(occupancy), 64'(q.size()));
    check("out_ctrl",  64'(out_ctrl),  has ? 64'(q[0].ctrl) : 64'(CR));
    check("out_pc",    64'(out_pc),    has ? 64'(q[0].pc)   : 64'(m_pc));
    check("out_data",  64'(out_data),  has ? 64'(q[0].data) : 64'(m_data));
`ifdef STAGE_PERF_EN
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
  endtask

  // Check current outputs, then advance one clock and update the model.
  task automatic step();
    bit   acc, tk;
    ent_t e;
    check_outputs();
    acc = in_valid && (q.size() != 2);
    tk  = (q.size() > 0) && out_ready;
    if (tk && !reset) taken.push_back(q[0].pc);
    e.ctrl = in_ctrl; e.pc = in_pc; e.data = in_data;
    @(posedge clk);
    if (reset) model_reset();
    else begin
      if (q.size() > 0 && !out_ready) m_stall = (m_stall + 1) % (1 << NW);
      if (flush) begin
        m_flush = (m_flush + 1) % (1 << NW);
        q.delete();
        m_data = '0;
        if (in_valid) m_pc = in_pc;
      end else begin
        if (tk)  void'(q.pop_front());
        if (acc) q.push_back(e);
      end
      if (q.size() > 0) begin
        m_pc   = q[0].pc;
        m_data = q[0].data;
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] pc, input logic [CW-1:0] c,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_ctrl   = c;
    in_data   = 32'($urandom);
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #1;
    model_reset();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    reset = 1'b0;

    // Fill both entries, then reset asynchronously mid-FULL.
    drive(1'b1, 32'h0000_00A0, 16'h1234, 1'b0, 1'b0); step();
    drive(1'b1, 32'h0000_00B0, 16'h5678, 1'b0, 1'b0); step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    async_reset();
    step();

    // Streaming at full throughput.
    taken.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i), 16'(i + 1), 1'b1, 1'b0);
      step();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0); step(); step();
    check("stream_takes", 64'(taken.size()), 64'd8);
    for (int i = 0; i < 8 && i < taken.size(); i++) check("stream_order", 64'(taken[i]), 64'(i));

    // Back-pressure: A, B held; C blocked; then drain.
    drive(1'b1, 32'h0000_0A00, 16'h00AA, 1'b0, 1'b0); step();
    drive(1'b1, 32'h0000_0B00, 16'h00BB, 1'b0, 1'b0); step();
    drive(1'b1, 32'h0000_0C00, 16'h00CC, 1'b0, 1'b0); step();
    drive(1'b0, '0, '0, 1'b1, 1'b0); step(); step(); step();

    // Flush while FULL with a valid input.
    drive(1'b1, 32'h0000_1000, 16'h0101, 1'b0, 1'b0); step();
    drive(1'b1, 32'h0000_2000, 16'h0202, 1'b0, 1'b0); step();
    drive(1'b1, 32'h0000_D000, 16'h0D0D, 1'b0, 1'b1); step();
    drive(1'b0, '0, '0, 1'b1, 1'b0); step(); step();

    // All-ones control then idle: bubbles must show CTRL_RESET.
    drive(1'b1, 32'h0000_3000, 16'hFFFF, 1'b1, 1'b0); step();
    drive(1'b0, '0, 16'hFFFF, 1'b1, 1'b0); step(); step(); step();

    // Stall and flush run long enough to wrap small counters.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h0000_4000 + 32'(i), 16'h0404, 1'b0, 1'b0); step();
    end
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1); step();
    end

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      drive(1'($urandom % 4 != 0), 32'($urandom), 16'($urandom),
            1'($urandom % 3 != 0), 1'($urandom % 25 == 0));
      if ($urandom % 300 == 0) async_reset();
      else step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
